// File: rtl/lcd_16207_sequencer.sv
// lcd_16207_sequencer: HD44780 bus timing master ahead of the 16207 LCD slave.
// Define LCD_SEQ_BUSY_POLL_EN for busy-flag polling; else fixed post-write delays.
module lcd_16207_sequencer #(
  parameter int POWERUP_CYCLES = 750000,
  parameter int HOLD_CYCLES    = 25,
  parameter int GAP_CYCLES     = 5,
  parameter int POLL_LIMIT     = 4096,
  parameter int DELAY_CYCLES   = 2500
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_is_cmd,
  output logic [1:0] lcd_address,
  output logic       lcd_begintransfer,
  output logic       lcd_read,
  output logic       lcd_write,
  output logic [7:0] lcd_writedata,
  input  logic [7:0] lcd_readdata,
  output logic       init_done,
  output logic       timeout
);

  typedef enum logic [2:0] {
    PWRUP, ACCESS, GAP, POLL, WAIT, IDLE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        wr_q, wr_d;
  logic        bt_q, bt_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        adv;
  logic        start_wr;
  logic        wr_cmd;
  logic [7:0]  wr_byte;

`ifdef LCD_SEQ_BUSY_POLL_EN
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        tmo_q, tmo_d;
  logic [31:0] poll_q, poll_d;
  logic        start_rd;
  logic [31:0] unused_delay;
  assign unused_delay = 32'(DELAY_CYCLES);
`else
  logic        cmd_q, cmd_d;
  logic [31:0] wait_last;
  logic        unused_rd;
  assign unused_rd = ^{lcd_readdata, 32'(POLL_LIMIT)};
  // clear-display and return-home need the long execution time
  assign wait_last =
    (cmd_q && (wdata_q == 8'h01 || wdata_q == 8'h02)) ?
    32'(40 * DELAY_CYCLES - 1) : 32'(DELAY_CYCLES - 1);
`endif

  function automatic logic [7:0] init_byte(input logic [1:0] i);
    unique case (i)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 32'd1;
    idx_d    = idx_q;
    wr_d     = wr_q;
    bt_d     = bt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdy_d    = rdy_q;
    done_d   = done_q;
    adv      = 1'b0;
    start_wr = 1'b0;
    wr_cmd   = 1'b1;
    wr_byte  = init_byte(2'd0);
`ifdef LCD_SEQ_BUSY_POLL_EN
    rd_d     = rd_q;
    busy_d   = busy_q;
    tmo_d    = tmo_q;
    poll_d   = poll_q;
    start_rd = 1'b0;
`else
    cmd_d    = cmd_q;
`endif
    unique case (state_q)
      PWRUP: begin
        if (cnt_q == 32'(POWERUP_CYCLES - 1)) start_wr = 1'b1;
      end
      IDLE: begin
        if (in_valid && rdy_q) begin
          rdy_d    = 1'b0;
          start_wr = 1'b1;
          wr_cmd   = in_is_cmd;
          wr_byte  = in_data;
        end
      end
      ACCESS, POLL: begin
        bt_d = 1'b0;
        if (cnt_q == 32'(HOLD_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          wr_d    = 1'b0;
`ifdef LCD_SEQ_BUSY_POLL_EN
          rd_d    = 1'b0;
          if (state_q == POLL) busy_d = lcd_readdata[7];
`endif
        end
      end
      GAP: begin
        if (cnt_q == 32'(GAP_CYCLES - 1)) begin
`ifdef LCD_SEQ_BUSY_POLL_EN
          // poll_q == 0 marks the gap that follows a write
          if (poll_q == '0) start_rd = 1'b1;
          else if (busy_q && poll_q < 32'(POLL_LIMIT)) start_rd = 1'b1;
          else begin
            tmo_d = tmo_q | busy_q;
            adv   = 1'b1;
          end
`else
          state_d = WAIT;
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
`ifdef LCD_SEQ_BUSY_POLL_EN
        adv = 1'b1;
`else
        if (cnt_q == wait_last) adv = 1'b1;
`endif
      end
      default: ;
    endcase

    if (adv) begin
      if (done_q) begin
        state_d = IDLE;
        rdy_d   = 1'b1;
      end else if (idx_q == 2'd3) begin
        state_d = IDLE;
        rdy_d   = 1'b1;
        done_d  = 1'b1;
      end else begin
        idx_d    = idx_q + 2'd1;
        start_wr = 1'b1;
        wr_byte  = init_byte(idx_q + 2'd1);
      end
    end

    if (start_wr) begin
      state_d = ACCESS;
      cnt_d   = '0;
      wr_d    = 1'b1;
      bt_d    = 1'b1;
      addr_d  = wr_cmd ? 2'd0 : 2'd2;
      wdata_d = wr_byte;
`ifdef LCD_SEQ_BUSY_POLL_EN
      poll_d  = '0;
`else
      cmd_d   = wr_cmd;
`endif
    end

`ifdef LCD_SEQ_BUSY_POLL_EN
    if (start_rd) begin
      state_d = POLL;
      cnt_d   = '0;
      rd_d    = 1'b1;
      bt_d    = 1'b1;
      addr_d  = 2'd1;
      poll_d  = poll_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      bt_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef LCD_SEQ_BUSY_POLL_EN
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      poll_q  <= '0;
`else
      cmd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      bt_q    <= bt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
`ifdef LCD_SEQ_BUSY_POLL_EN
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      poll_q  <= poll_d;
`else
      cmd_q   <= cmd_d;
`endif
    end
  end

  assign in_ready          = rdy_q;
  assign lcd_address       = addr_q;
  assign lcd_begintransfer = bt_q;
  assign lcd_write         = wr_q;
  assign lcd_writedata     = wdata_q;
  assign init_done         = done_q;
`ifdef LCD_SEQ_BUSY_POLL_EN
  assign lcd_read          = rd_q;
  assign timeout           = tmo_q;
`else
  assign lcd_read          = 1'b0;
  assign timeout           = 1'b0;
`endif

endmodule
